// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard scoreboard
package pipe_pkg;
  localparam int DEF_DEPTH = 3;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1, ST_FREEZE = 2'd2} state_t;
  typedef struct packed {
    logic v;
    logic [4:0] dest;
  } entry_t;
endpackage

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: shift register of destination tags from EXE (entry 0) to WB (entry DEPTH-1)
module hazard_tag_pipe
  import pipe_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  entry_t                ins,
  output entry_t [DEPTH-1:0]    entries
);
  entry_t [DEPTH-1:0] ent_q, ent_d;
  always_comb begin
    ent_d = shift_en ? {ent_q[DEPTH-2:0], ins} : ent_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ent_q <= '0;
    else ent_q <= ent_d;
  end
  assign entries = ent_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW stall, memory freeze and branch flush scheduler beside the ID stage
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             uses_src2,
  input  logic             id_wb_en,
  input  logic [4:0]       id_dest,
  input  logic             mem_busy,
  input  logic             br_taken,
  output logic             hazard_stall,
  output logic             pipe_freeze,
  output logic             flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);
  entry_t [DEPTH-1:0] ents;
  entry_t ins;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic match, issue;
  hazard_tag_pipe #(.DEPTH(DEPTH)) u_tags (
    .clk(clk),
    .rst(rst),
    .shift_en(~pipe_freeze),
    .ins(ins),
    .entries(ents)
  );
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      match = match | (ents[i].v & ((ents[i].dest == src1) | (uses_src2 & (ents[i].dest == src2))));
    match = match & id_valid;
    pipe_freeze = mem_busy & ~rst;
    flush = br_taken & ~mem_busy & ~rst;
    hazard_stall = match & ~flush & ~pipe_freeze & ~rst;
    issue = id_valid & ~hazard_stall & ~flush & ~pipe_freeze;
    // register 0 is stored invalid so it can never match a reader
    ins = issue ? {id_wb_en & (id_dest != REG_ZERO), id_dest} : '0;
    case (state_q)
      ST_FREEZE: state_d = mem_busy ? ST_FREEZE : (match & ~br_taken) ? ST_STALL : ST_RUN;
      default:   state_d = mem_busy ? ST_FREEZE : hazard_stall ? ST_STALL : ST_RUN;
    endcase
    cnt_d = ((hazard_stall | pipe_freeze) & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign state = state_q;
  assign stall_count = cnt_q;
endmodule
